ahb3lite_slave: RTL and testbench
=================================

// Module: ahb3lite_slave
// PURPOSE
// - AHB-Lite (AMBA 3) memory-mapped slave backed by a word-organised, byte-writable RAM.
// - Accepts pipelined single and burst transfers from one master; bursts are handled beat by beat.
// - Zero wait states by default. Signals illegal accesses with the two-cycle ERROR response.
// PARAMETERS
// - ADDR_WIDTH   32    HADDR width
// - DATA_WIDTH   32    HWDATA/HRDATA width (fixed at 32)
// - MEM_DEPTH    1024  RAM depth in 32-bit words; legal byte range 0 .. MEM_DEPTH*4-1
// - WAIT_CYCLES  1     wait states per OKAY transfer, used only when AHB3LITE_WAIT_EN is defined
// PORTS
// - HCLK       in   1   clock; all logic on the rising edge
// - HRESETn    in   1   reset, asynchronous and active-low
// - HSEL       in   1   slave select
// - HADDR      in   32  byte address
// - HWDATA     in   32  write data, valid in the data phase
// - HRDATA     out  32  read data, valid in the data phase when HREADYOUT=1
// - HWRITE     in   1   1=write, 0=read
// - HSIZE      in   3   0=byte, 1=halfword, 2=word
// - HBURST     in   3   burst type; accepted and otherwise ignored
// - HPROT      in   4   protection; accepted and otherwise ignored
// - HTRANS     in   2   0=IDLE, 1=BUSY, 2=NONSEQ, 3=SEQ
// - HREADYOUT  out  1   1 = this slave's data phase completes this cycle
// - HREADY     in   1   bus ready (may be tied to 1)
// - HRESP      out  1   0=OKAY, 1=ERROR
// BEHAVIOUR
// - Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, address-phase registers cleared.
//   Reset is honoured mid-transfer; RAM contents are not cleared.
// - Address phase is sampled when HSEL & HREADY & HREADYOUT.
//   The transfer is active only if HTRANS is NONSEQ or SEQ.
//   Registered fields: addr, size, write, valid.
// - IDLE and BUSY transfers, and cycles with HSEL=0: OKAY response, zero wait, no RAM access.
// - Error conditions (ERROR response, no RAM access):
//   - HSIZE>2;
//   - misalignment: halfword with addr[0]=1, or word with addr[1:0]!=0;
//   - address >= MEM_DEPTH*4.
// - ERROR timing, in the data phase:
//   - cycle 1: HREADYOUT=0, HRESP=1;
//   - cycle 2: HREADYOUT=1, HRESP=1;
//   - then HRESP returns to 0.
//   - The next address phase is not sampled during cycle 1.
// - Write: RAM is updated at the end of the data phase using HWDATA and little-endian byte lanes.
//   - byte: lane addr[1:0];
//   - halfword: lanes {addr[1],0} and {addr[1],1};
//   - word: all lanes.
// - Read: HRDATA = full RAM word at addr[ADDR_WIDTH-1:2] during the data phase.
//   - Outside a read data phase, HRDATA holds 0.
// - Read-after-write to the same address in back-to-back transfers returns the new data.
//   No stall is allowed for this case.
// - Latency: the data phase is the cycle after the address phase; OKAY transfers have zero wait.
// - FSM: IDLE -> (error) ERR1 -> ERR2 -> IDLE/next.
//   With the macro defined: IDLE -> WAIT (count) -> IDLE.
// - Control signals must stay stable while HREADYOUT=0; the slave ignores changes until ready.
// CONFIGURATION
// - Macro AHB3LITE_WAIT_EN.
//   - Defined: each OKAY NONSEQ/SEQ transfer inserts WAIT_CYCLES cycles of HREADYOUT=0, HRESP=0,
//     then completes. RAM write and read data are committed/valid in the final (ready) cycle.
//   - Undefined: zero-wait operation; the wait counter is not instantiated.
// STRUCTURE
// - Package ahb3lite_pkg:
//   - htrans_t enum (IDLE/BUSY/NONSEQ/SEQ);
//   - hsize constants (BYTE/HALF/WORD);
//   - HRESP_OKAY/HRESP_ERROR;
//   - FSM state enum.
// - Sub-module ahb3lite_sram: MEM_DEPTH x 32 RAM with 4-bit byte-enable write and async read.
// - Top: address-phase registers, decode/error check, response FSM, byte-enable generation.
// TESTING
// - Reset: HRESETn=0 for 2 cycles -> HREADYOUT=1, HRESP=0, HRDATA=0.
// - Word write then read: write 0xDEADBEEF to 0x10, then read 0x10
//   -> HRDATA=0xDEADBEEF, HRESP=0, no wait.
// - Byte/halfword:
//   - word 0x0 at 0x20, then byte 0xAA at 0x23, then halfword 0x5566 at 0x20
//     -> read 0x20 = 0xAA005566.
// - Burst: INCR4 SEQ words 1,2,3,4 from 0x40, read back as INCR4
//   -> 1,2,3,4, back-to-back, all OKAY.
// - Errors: each of the following -> two-cycle ERROR (0/1, then 1/1), RAM unchanged:
//   - read at MEM_DEPTH*4;
//   - word at 0x02;
//   - HSIZE=3.
// - IDLE/BUSY/HSEL=0 with HWRITE=1 -> OKAY, zero wait, RAM unchanged.
//   Assert HREADYOUT=1 whenever no data phase is pending.

Source files
------------

// File: rtl/ahb3lite_pkg.sv
// ----------------------------------------------------------------------------
// ahb3lite_pkg
// Shared types and constants for the AHB-Lite memory slave:
//   - htrans_t      : AHB transfer type encoding (IDLE/BUSY/NONSEQ/SEQ)
//   - HSIZE_*       : supported transfer sizes (byte/halfword/word)
//   - HRESP_*       : response encoding
//   - state_t       : response FSM states
//   - byte_enable() : little-endian byte-lane mask for a size/offset pair
//   - size_addr_illegal() : unsupported size or misaligned offset
// No ports (package).
// ----------------------------------------------------------------------------
package ahb3lite_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Number of byte lanes in one RAM word.
    localparam int DATA_BYTES = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // ready, OKAY (also the completing cycle of any OKAY transfer)
        ST_WAIT = 2'd1,   // inserted wait states (only reachable with wait states enabled)
        ST_ERR1 = 2'd2,   // first ERROR cycle: not ready
        ST_ERR2 = 2'd3    // second ERROR cycle: ready
    } state_t;

    function automatic logic [DATA_BYTES-1:0] byte_enable(input logic [2:0] size,
                                                         input logic [1:0] lo);
        logic [DATA_BYTES-1:0] be;
        be = '0;
        case (size)
            HSIZE_BYTE: be = 4'b0001 << lo;
            HSIZE_HALF: be = lo[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: be = 4'b1111;
            default:    be = '0;
        endcase
        return be;
    endfunction

    function automatic logic size_addr_illegal(input logic [2:0] size,
                                               input logic [1:0] lo);
        return (size > HSIZE_WORD)
            || ((size == HSIZE_HALF) && lo[0])
            || ((size == HSIZE_WORD) && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/ahb3lite_sram.sv
// ----------------------------------------------------------------------------
// ahb3lite_sram
// DEPTH x 32-bit RAM, one write port with per-byte enables and one
// asynchronous (combinational) read port. Contents are never reset.
// Ports:
//   clk    in  1      write clock (rising edge)
//   waddr  in  IDX_W  word index for writes
//   we     in  4      byte-lane write enables, lane 0 = bits [7:0]
//   wdata  in  32     write data
//   raddr  in  IDX_W  word index for reads
//   rdata  out 32     read data (combinational)
// ----------------------------------------------------------------------------
module ahb3lite_sram
    import ahb3lite_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic [IDX_W-1:0]      waddr,
    input  logic [DATA_BYTES-1:0] we,
    input  logic [31:0]           wdata,
    input  logic [IDX_W-1:0]      raddr,
    output logic [31:0]           rdata
);

    // One independent byte-wide array per lane so each lane has a single writer.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_BYTES; gi++) begin : g_lane
            logic [7:0] mem_lane [DEPTH];

            always_ff @(posedge clk) begin
                if (we[gi]) begin
                    mem_lane[waddr] <= wdata[gi*8 +: 8];
                end
            end

            assign rdata[gi*8 +: 8] = mem_lane[raddr];
        end
    endgenerate

endmodule

// File: rtl/ahb3lite_slave.sv
// ----------------------------------------------------------------------------
// ahb3lite_slave
// AHB-Lite slave backed by a byte-writable word RAM. Pipelined single and
// burst transfers are handled beat by beat; illegal accesses (size > word,
// misaligned, or beyond MEM_DEPTH*4) get the two-cycle ERROR response and
// never touch the RAM.
//
// Optional feature: define AHB3LITE_WAIT_EN to insert WAIT_CYCLES wait states
// into every OKAY NONSEQ/SEQ transfer. Without it the slave is zero-wait and
// has no wait counter.
//
// Ports:
//   HCLK      in  1   clock
//   HRESETn   in  1   asynchronous active-low reset
//   HSEL      in  1   slave select
//   HADDR     in  AW  byte address
//   HWDATA    in  DW  write data (data phase)
//   HRDATA    out DW  read data (0 outside a read data phase)
//   HWRITE    in  1   1=write
//   HSIZE     in  3   0=byte 1=half 2=word
//   HBURST    in  3   ignored
//   HPROT     in  4   ignored
//   HTRANS    in  2   IDLE/BUSY/NONSEQ/SEQ
//   HREADYOUT out 1   data phase completes this cycle
//   HREADY    in  1   bus ready
//   HRESP     out 1   0=OKAY 1=ERROR
// ----------------------------------------------------------------------------
module ahb3lite_slave
    import ahb3lite_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    output logic [DATA_WIDTH-1:0] HRDATA,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic [1:0]            HTRANS,
    output logic                  HREADYOUT,
    input  logic                  HREADY,
    output logic                  HRESP
);

    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(MEM_DEPTH) << 2;

    // ------------------------------------------------------------------
    // Address-phase decode
    // ------------------------------------------------------------------
    logic trans_active;
    logic addr_oob;
    logic req_err;
    logic req_ok;
    logic ready_out;
    logic resp_out;
    logic phase_take;

    assign trans_active = HSEL && ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));
    assign addr_oob     = ({1'b0, HADDR} >= MEM_BYTES);
    assign req_err      = trans_active && (size_addr_illegal(HSIZE, HADDR[1:0]) || addr_oob);
    assign req_ok       = trans_active && !req_err;
    // A new address phase is only accepted while our own data phase is ready,
    // which is what holds off sampling during the first ERROR cycle and waits.
    assign phase_take   = HREADY && ready_out;

    // ------------------------------------------------------------------
    // Address-phase registers (valid only for OKAY NONSEQ/SEQ transfers)
    // ------------------------------------------------------------------
    logic             valid_reg;
    logic             write_reg;
    logic [2:0]       size_reg;
    logic [IDX_W-1:0] word_reg;
    logic [1:0]       lo_reg;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            valid_reg <= 1'b0;
            write_reg <= 1'b0;
            size_reg  <= 3'd0;
            word_reg  <= '0;
            lo_reg    <= 2'b00;
        end else if (phase_take) begin
            valid_reg <= req_ok;
            write_reg <= HWRITE;
            size_reg  <= HSIZE;
            word_reg  <= HADDR[IDX_W+1:2];
            lo_reg    <= HADDR[1:0];
        end
    end

    // ------------------------------------------------------------------
    // Response FSM
    // ------------------------------------------------------------------
    state_t state_reg;
    state_t state_next;
    state_t take_next;

`ifdef AHB3LITE_WAIT_EN
    localparam int WCNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    logic [WCNT_W-1:0] wait_cnt_reg;

    always_comb begin
        take_next = ST_IDLE;
        if (req_err) begin
            take_next = ST_ERR1;
        end else if (req_ok && (WAIT_CYCLES > 0)) begin
            take_next = ST_WAIT;
        end
    end

    // Loaded on entry to WAIT; WAIT is left when the last wait cycle is counted.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wait_cnt_reg <= '0;
        end else if ((state_next == ST_WAIT) && (state_reg != ST_WAIT)) begin
            wait_cnt_reg <= WCNT_W'(WAIT_CYCLES);
        end else if (state_reg == ST_WAIT) begin
            wait_cnt_reg <= wait_cnt_reg - 1'b1;
        end
    end
`else
    assign take_next = req_err ? ST_ERR1 : ST_IDLE;
`endif

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ready_out  = 1'b1;
        resp_out   = HRESP_OKAY;
        case (state_reg)
            ST_IDLE: begin
                if (HREADY) begin
                    state_next = take_next;
                end
            end
            ST_ERR1: begin
                ready_out  = 1'b0;
                resp_out   = HRESP_ERROR;
                state_next = ST_ERR2;
            end
            ST_ERR2: begin
                resp_out = HRESP_ERROR;
                if (HREADY) begin
                    state_next = take_next;
                end
            end
`ifdef AHB3LITE_WAIT_EN
            ST_WAIT: begin
                ready_out = 1'b0;
                if (wait_cnt_reg <= WCNT_W'(1)) begin
                    state_next = ST_IDLE;
                end
            end
`endif
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign HREADYOUT = ready_out;
    assign HRESP     = resp_out;

    // ------------------------------------------------------------------
    // RAM: writes commit in the completing cycle of the data phase, so a
    // read issued right behind a write sees the new word without a stall.
    // ------------------------------------------------------------------
    logic [DATA_BYTES-1:0] ram_we;
    logic [31:0]           ram_rdata;

    assign ram_we = (valid_reg && write_reg && ready_out && HREADY)
                  ? byte_enable(size_reg, lo_reg) : '0;

    ahb3lite_sram #(
        .DEPTH (MEM_DEPTH),
        .IDX_W (IDX_W)
    ) u_sram (
        .clk   (HCLK),
        .waddr (word_reg),
        .we    (ram_we),
        .wdata (HWDATA),
        .raddr (word_reg),
        .rdata (ram_rdata)
    );

    assign HRDATA = (valid_reg && !write_reg) ? ram_rdata : '0;

    // Burst type and protection are accepted but play no part in decoding.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, HBURST, HPROT, (WAIT_CYCLES != 0)};

endmodule

// File: tb/tb_ahb3lite_slave.sv
module tb_ahb3lite_slave;
    import ahb3lite_pkg::*;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;
    logic        HREADYOUT;
    logic        HREADY;
    logic        HRESP;

    ahb3lite_slave #(
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32),
        .MEM_DEPTH   (1024),
        .WAIT_CYCLES (1)
    ) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HWDATA    (HWDATA),
        .HRDATA    (HRDATA),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HBURST    (HBURST),
        .HPROT     (HPROT),
        .HTRANS    (HTRANS),
        .HREADYOUT (HREADYOUT),
        .HREADY    (HREADY),
        .HRESP     (HRESP)
    );

    always #5 HCLK = ~HCLK;

    int cyc = 0;
    always @(posedge HCLK) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic        rdy;
        logic        resp;
        logic [31:0] data;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] pend_wdata = 32'h0;

    localparam logic [1:0] T_IDLE = 2'b00;
    localparam logic [1:0] T_BUSY = 2'b01;
    localparam logic [1:0] T_NSEQ = 2'b10;
    localparam logic [1:0] T_SEQ  = 2'b11;

    // Monitor: each negedge, pop every expectation due this cycle and compare.
    always @(negedge HCLK) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            total++;
            if (e.cyc != cyc || HREADYOUT !== e.rdy || HRESP !== e.resp || HRDATA !== e.data) begin
                bad++;
                $display("FAIL %s cyc=%0d/%0d: got rdy=%b resp=%b data=%h, need rdy=%b resp=%b data=%h",
                         e.name, cyc, e.cyc, HREADYOUT, HRESP, HRDATA, e.rdy, e.resp, e.data);
            end else begin
                $display("ok   %s cyc=%0d rdy=%b resp=%b data=%h", e.name, cyc, HREADYOUT, HRESP, HRDATA);
            end
        end
    end

    task automatic push(input int c, input logic r, input logic s, input logic [31:0] d, input string nm);
        exp_t e;
        e.cyc = c; e.rdy = r; e.resp = s; e.data = d; e.name = nm;
        sb.push_back(e);
    endtask

    // One bus cycle: new address phase plus the pending write data of the previous one.
    task automatic drive(input logic sel, input logic [1:0] tr, input logic wr,
                         input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
        HSEL   = sel;
        HTRANS = tr;
        HWRITE = wr;
        HSIZE  = sz;
        HADDR  = a;
        HWDATA = pend_wdata;
        pend_wdata = wd;
        @(posedge HCLK);
        #1;
    endtask

    // OKAY, zero-wait transfer: data phase is the next cycle.
    task automatic xfer(input logic sel, input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] exp_d,
                        input string nm);
        push(cyc + 1, 1'b1, HRESP_OKAY, exp_d, nm);
        drive(sel, tr, wr, sz, a, wd);
    endtask

    // Illegal transfer: two ERROR cycles; the IDLE offered in ERR1 is not sampled.
    task automatic err_xfer(input logic wr, input logic [2:0] sz, input logic [31:0] a,
                            input logic [31:0] wd, input string nm);
        push(cyc + 1, 1'b0, HRESP_ERROR, 32'h0, {nm, "_e1"});
        push(cyc + 2, 1'b1, HRESP_ERROR, 32'h0, {nm, "_e2"});
        drive(1'b1, T_NSEQ, wr, sz, a, wd);
        drive(1'b1, T_IDLE, 1'b0, HSIZE_WORD, 32'h0, 32'h0);
    endtask

    initial begin
        HRESETn = 1'b0;
        HSEL = 1'b0; HADDR = 32'h0; HWDATA = 32'h0; HWRITE = 1'b0;
        HSIZE = 3'd0; HBURST = 3'd0; HPROT = 4'b0011; HTRANS = T_IDLE; HREADY = 1'b1;

        push(1, 1'b1, HRESP_OKAY, 32'h0, "reset1");
        push(2, 1'b1, HRESP_OKAY, 32'h0, "reset2");
        repeat (2) @(posedge HCLK);
        #1;
        HRESETn = 1'b1;

        // Word write then back-to-back read
        xfer(1, T_NSEQ, 1, HSIZE_WORD, 32'h10, 32'hDEADBEEF, 32'h0, "wr_word_10");
        xfer(1, T_NSEQ, 0, HSIZE_WORD, 32'h10, 32'h0, 32'hDEADBEEF, "rd_word_10");

        // Byte and halfword lanes
        xfer(1, T_NSEQ, 1, HSIZE_WORD, 32'h20, 32'h0000_0000, 32'h0, "wr_word_20");
        xfer(1, T_NSEQ, 1, HSIZE_BYTE, 32'h23, 32'hAA00_0000, 32'h0, "wr_byte_23");
        xfer(1, T_NSEQ, 1, HSIZE_HALF, 32'h20, 32'h0000_5566, 32'h0, "wr_half_20");
        xfer(1, T_NSEQ, 0, HSIZE_WORD, 32'h20, 32'h0, 32'hAA00_5566, "rd_word_20");

        // INCR4 write burst then INCR4 read burst
        HBURST = 3'b011;
        xfer(1, T_NSEQ, 1, HSIZE_WORD, 32'h40, 32'd1, 32'h0, "bwr0");
        xfer(1, T_SEQ,  1, HSIZE_WORD, 32'h44, 32'd2, 32'h0, "bwr1");
        xfer(1, T_SEQ,  1, HSIZE_WORD, 32'h48, 32'd3, 32'h0, "bwr2");
        xfer(1, T_SEQ,  1, HSIZE_WORD, 32'h4C, 32'd4, 32'h0, "bwr3");
        xfer(1, T_NSEQ, 0, HSIZE_WORD, 32'h40, 32'h0, 32'd1, "brd0");
        xfer(1, T_SEQ,  0, HSIZE_WORD, 32'h44, 32'h0, 32'd2, "brd1");
        xfer(1, T_SEQ,  0, HSIZE_WORD, 32'h48, 32'h0, 32'd3, "brd2");
        xfer(1, T_SEQ,  0, HSIZE_WORD, 32'h4C, 32'h0, 32'd4, "brd3");
        HBURST = 3'b000;

        // Errors, with RAM-unchanged readback
        xfer(1, T_NSEQ, 1, HSIZE_WORD, 32'h0, 32'h1234_5678, 32'h0, "wr_word_00");
        err_xfer(0, HSIZE_WORD, 32'h1000, 32'h0, "err_oob_rd");
        err_xfer(1, HSIZE_WORD, 32'h02, 32'hFFFF_FFFF, "err_misal_word");
        err_xfer(1, 3'd3, 32'h0, 32'hFFFF_FFFF, "err_size3");
        err_xfer(1, HSIZE_HALF, 32'h01, 32'hFFFF_FFFF, "err_misal_half");
        xfer(1, T_NSEQ, 0, HSIZE_WORD, 32'h0, 32'h0, 32'h1234_5678, "rd_after_err");

        // IDLE / BUSY / unselected writes must not touch the RAM
        xfer(1, T_IDLE, 1, HSIZE_WORD, 32'h10, 32'h0BAD_0001, 32'h0, "idle_wr");
        xfer(1, T_BUSY, 1, HSIZE_WORD, 32'h10, 32'h0BAD_0002, 32'h0, "busy_wr");
        xfer(0, T_NSEQ, 1, HSIZE_WORD, 32'h10, 32'h0BAD_0003, 32'h0, "nosel_wr");
        xfer(1, T_NSEQ, 0, HSIZE_WORD, 32'h10, 32'h0, 32'hDEADBEEF, "rd_10_kept");

        // Trailing idle cycles: outputs back at rest
        xfer(1, T_IDLE, 0, HSIZE_WORD, 32'h0, 32'h0, 32'h0, "idle_tail0");
        xfer(0, T_IDLE, 0, HSIZE_WORD, 32'h0, 32'h0, 32'h0, "idle_tail1");
        repeat (3) @(posedge HCLK);
        #1;

        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending, need 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
